uart_tx: RTL and testbench

Byte-serial UART transmitter that drains the byte stream produced by the FIFO queue and drives the board TX pin. Each accepted byte is sent as one 8N1 frame (8N2 if `StopBits` is 2) at the baud rate set by `UartCmpVal` from the shared configuration package. It sits directly downstream of the FIFO read port and has no CSR interface of its own.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx.sv | 119 +++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART configuration: the one place the baud setting lives, plus the
// transmitter's state and data types.
package uart_tx_pkg;

    localparam int UartClkHz    = 20_000_000;
    localparam int UartBaudRate = 115_200;
    // Truncating division: 20 MHz / 115200 gives 173 cycles per bit.
    localparam int UartCmpVal   = UartClkHz / UartBaudRate;
    localparam int UartStopBits = 1;

    typedef enum logic [1:0] {
        Idle,
        Start,
        Data,
        Stop
    } UartStateT;

    typedef logic [7:0] UartDataT;

endpackage

// File: rtl/uart_tx.sv
// Byte-serial 8N1/8N2 UART transmitter fed by a valid/ready stream; the line
// output is registered so the pin never glitches.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CmpVal   = UartCmpVal,
    parameter int StopBits = UartStopBits
) (
    input  logic     clk,
    input  logic     reset,
    input  UartDataT data_i,
    input  logic     valid_i,
    output logic     ready_o,
    output logic     tx_o,
    output logic     busy_o
);

    if (CmpVal < 2) begin : g_bad_cmpval
        $error("uart_tx: CmpVal must be >= 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stopbits
        $error("uart_tx: StopBits must be 1 or 2");
    end

    localparam int               CntW     = $clog2(CmpVal);
    localparam logic [CntW-1:0]  CntMax   = CntW'(CmpVal - 1);
    localparam logic             StopLast = 1'(StopBits - 1);

    UartStateT       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    UartDataT        shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign ready_o = (state_q == Idle) && !reset;
    assign busy_o  = (state_q != Idle);
    assign tx_o    = tx_q;
    assign bit_end = (cnt_q == CntMax);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = 1'b1;

        if (state_q != Idle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            Idle: begin
                cnt_d = '0;
                if (valid_i && ready_o) begin
                    state_d    = Start;
                    shift_d    = data_i;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                end
            end
            Start: begin
                if (bit_end) begin
                    state_d   = Data;
                    bit_idx_d = 3'd0;
                end
            end
            Data: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = Stop;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            Stop: begin
                if (bit_end) begin
                    if (stop_cnt_q == StopLast) begin
                        state_d = Idle;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = Idle;
        endcase

        // Line level is decoded from the next state so it lands in tx_q on the
        // same edge as the state change.
        case (state_d)
            Start:   tx_d = 1'b0;
            Data:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= Idle;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench: three transmitters (4 cycles/bit 1 stop, 4 cycles/bit
// 2 stop, default baud) checked cycle by cycle against an ideal frame model.
module tb_uart_tx;
    import uart_tx_pkg::*;

    logic       clk = 1'b0;
    logic [2:0] rst_r;
    logic [2:0] valid_r;
    logic [2:0] tx_w;
    logic [2:0] ready_w;
    logic [2:0] busy_w;
    logic [7:0] data_r [3];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CmpVal(4), .StopBits(1)) u_dut0 (
        .clk(clk), .reset(rst_r[0]), .data_i(data_r[0]), .valid_i(valid_r[0]),
        .ready_o(ready_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]));

    uart_tx #(.CmpVal(4), .StopBits(2)) u_dut1 (
        .clk(clk), .reset(rst_r[1]), .data_i(data_r[1]), .valid_i(valid_r[1]),
        .ready_o(ready_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]));

    uart_tx u_dut2 (
        .clk(clk), .reset(rst_r[2]), .data_i(data_r[2]), .valid_i(valid_r[2]),
        .ready_o(ready_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]));

    function automatic int cmp_of(input int d);
        return (d == 2) ? UartCmpVal : 4;
    endfunction

    function automatic int sb_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    // Ideal frame: bit slot 0 is the start bit, 1..8 are data LSB first, rest stop.
    function automatic logic exp_bit(input logic [7:0] val, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return val[slot-1];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge inside an Idle cycle; returns at the negedge of the
    // first start-bit cycle.
    task automatic start_byte(input int d, input logic [7:0] val);
        data_r[d]  = val;
        valid_r[d] = 1'b1;
        #1;
        check("ready_pre", 32'(ready_w[d]), 32'd1);
        @(negedge clk);
    endtask

    // Walks one whole frame from its first cycle, checking the line every cycle
    // and decoding mid-bit like a receiver. Returns at the following Idle cycle.
    task automatic run_frame(input int d, input logic [7:0] val, input bit scramble, input bit hold);
        int         cmp = cmp_of(d);
        int         sb  = sb_of(d);
        int         slot;
        logic [7:0] rx  = 8'h00;
        for (int c = 0; c < (9 + sb) * cmp; c++) begin
            slot = c / cmp;
            check($sformatf("dut%0d tx c%0d", d, c), 32'(tx_w[d]), 32'(exp_bit(val, slot)));
            check("busy_frame", 32'(busy_w[d]), 32'd1);
            check("ready_frame", 32'(ready_w[d]), 32'd0);
            if (slot >= 1 && slot <= 8 && (c % cmp) == cmp / 2) rx[slot-1] = tx_w[d];
            if (!hold) valid_r[d] = 1'b0;
            if (scramble && !hold) begin
                data_r[d]  = 8'($urandom);
                valid_r[d] = 1'($urandom);
            end
            @(negedge clk);
        end
        if (!hold) valid_r[d] = 1'b0;
        check("rx_byte", 32'(rx), 32'(val));
        check("ready_end", 32'(ready_w[d]), 32'd1);
        check("busy_end", 32'(busy_w[d]), 32'd0);
        check("tx_idle", 32'(tx_w[d]), 32'd1);
        $display("dut%0d frame %02h decoded %02h", d, val, rx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        rst_r   = 3'b111;
        valid_r = 3'b000;
        for (int i = 0; i < 3; i++) data_r[i] = 8'h00;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(ready_w[d]), 32'd0);
            check("rst_tx", 32'(tx_w[d]), 32'd1);
            check("rst_busy", 32'(busy_w[d]), 32'd0);
        end
        rst_r = 3'b000;
        #1;
        check("ready_after_rst", 32'(ready_w[0]), 32'd1);

        // Quiet line after reset.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx_w[0]), 32'd1);
            check("idle_ready", 32'(ready_w[0]), 32'd1);
            check("idle_busy", 32'(busy_w[0]), 32'd0);
        end

        start_byte(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 1'b0);

        // Back-to-back with valid held: data_i changes mid-frame and must only
        // be picked up at the second handshake, one Idle cycle later.
        start_byte(0, 8'h00);
        data_r[0] = 8'hFF;
        run_frame(0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        valid_r[0] = 1'b0;
        run_frame(0, 8'hFF, 1'b0, 1'b0);

        // Abort during D3 of 0x55.
        start_byte(0, 8'h55);
        valid_r[0] = 1'b0;
        for (int c = 0; c < 18; c++) begin
            check("abort_pre_tx", 32'(tx_w[0]), 32'(exp_bit(8'h55, c / 4)));
            @(negedge clk);
        end
        rst_r[0] = 1'b1;
        #1;
        check("abort_ready_in_rst", 32'(ready_w[0]), 32'd0);
        @(negedge clk);
        check("abort_tx", 32'(tx_w[0]), 32'd1);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        rst_r[0] = 1'b0;
        #1;
        check("abort_ready", 32'(ready_w[0]), 32'd1);
        start_byte(0, 8'h0F);
        run_frame(0, 8'h0F, 1'b0, 1'b0);

        // Random bytes with random gaps and a noisy upstream while busy.
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = 8'($urandom);
            start_byte(0, b);
            run_frame(0, b, 1'b1, 1'b0);
        end

        // Two stop bits.
        start_byte(1, 8'h80);
        run_frame(1, 8'h80, 1'b0, 1'b0);
        for (int n = 0; n < 2; n++) begin
            b = 8'($urandom);
            start_byte(1, b);
            run_frame(1, b, 1'b1, 1'b0);
        end

        // Default baud divisor.
        start_byte(2, 8'h41);
        run_frame(2, 8'h41, 1'b0, 1'b0);
        b = 8'($urandom);
        start_byte(2, b);
        run_frame(2, b, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
